pla16_stim_driver: RTL and testbench

Self-checking stimulus source and response compactor for 16-input / 1-output combinational benchmark cores. It drives a 16-bit pseudo-random vector onto the core inputs each cycle and samples the core's single output in the same cycle. Samples are folded into a 16-bit serial signature and a ones count. It sits on the input side of the benchmark core in the power-characterisation harness, driving the core's inputs and consuming its output.

---
 rtl/pla16_stim_driver.sv | 119 +++++++++++
 tb/tb_pla16_stim_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pla16_stim_driver.sv
// rtl/pla16_stim_driver.sv - LFSR stimulus source and serial-signature response compactor for 16-in/1-out cores.
// Optional toggle counter built only when PLA16_TOGGLE_CNT_EN is defined.
module pla16_stim_driver #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_VECTORS = 1024,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec,
  input  logic             resp,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic [15:0]      vec_q, vec_d;
  logic [15:0]      sig_q, sig_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      next_vec;
  logic             start_acc;
  logic             run_step;

  assign next_vec  = {vec_q[14:0], vec_q[15] ^ vec_q[13] ^ vec_q[12] ^ vec_q[10]};
  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign run_step  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    sig_d   = sig_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = SEED_EFF;
          sig_d   = '0;
          ones_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ resp};
        if (resp && ones_q != {CNT_W{1'b1}}) ones_d = ones_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        vec_d = next_vec;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      sig_q   <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PLA16_TOGGLE_CNT_EN
  // Switching-activity proxy: bits that flip between consecutive applied vectors.
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W:0]   tog_sum;

  assign tog_sum = {1'b0, tog_q} + (CNT_W+1)'(popcnt16(vec_q ^ next_vec));

  always_comb begin
    tog_d = tog_q;
    if (start_acc)     tog_d = '0;
    else if (run_step) tog_d = tog_sum[CNT_W] ? {CNT_W{1'b1}} : tog_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) tog_q <= '0;
    else     tog_q <= tog_d;
  end

  assign toggle_cnt = tog_q;
`else
  logic unused_ok;
  assign unused_ok  = start_acc ^ run_step;
  assign toggle_cnt = '0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign vec       = vec_q;
  assign signature = sig_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_pla16_stim_driver.sv
// tb/tb_pla16_stim_driver.sv - directed self-checking bench for pla16_stim_driver (three parameterisations).
module tb_pla16_stim_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // A: default parameters, resp driven by the bench
  logic        start_a = 1'b0, resp_a = 1'b0;
  logic        busy_a, done_a;
  logic [15:0] vec_a, sig_a, ones_a, tog_a;

  // B: single-vector run, resp tied high
  logic        start_b = 1'b0;
  logic        busy_b, done_b;
  logic [15:0] vec_b, sig_b, ones_b, tog_b;

  // C: zero seed replaced by 1, four vectors, resp = vec[0]
  logic        start_c = 1'b0;
  logic        busy_c, done_c;
  logic [15:0] vec_c, sig_c, ones_c, tog_c;

  pla16_stim_driver u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .vec(vec_a),
    .resp(resp_a), .signature(sig_a), .ones_cnt(ones_a), .toggle_cnt(tog_a)
  );

  pla16_stim_driver #(.NUM_VECTORS(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .vec(vec_b),
    .resp(1'b1), .signature(sig_b), .ones_cnt(ones_b), .toggle_cnt(tog_b)
  );

  pla16_stim_driver #(.SEED(16'h0000), .NUM_VECTORS(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .vec(vec_c),
    .resp(vec_c[0]), .signature(sig_c), .ones_cnt(ones_c), .toggle_cnt(tog_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PLA16_TOGGLE_CNT_EN
  localparam logic [15:0] TOG_FIRST = 16'd8;
  localparam logic [15:0] TOG_C     = 16'd8;
`else
  localparam logic [15:0] TOG_FIRST = 16'd0;
  localparam logic [15:0] TOG_C     = 16'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nb;

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_vec", vec_a, 0);
    check("rst_sig", sig_a, 0);

    // A: first two patterns and toggle count
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a_c1_vec", vec_a, 16'hACE1);
    check("a_c1_busy", busy_a, 1);
    check("a_c1_done", done_a, 0);
    tick();
    check("a_c2_vec", vec_a, 16'h59C3);
    check("a_c2_tog", tog_a, TOG_FIRST);

    // A: mid-run reset held 2 cycles
    resp_a = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("mrst_busy", busy_a, 0);
    check("mrst_done", done_a, 0);
    check("mrst_vec", vec_a, 0);
    check("mrst_sig", sig_a, 0);
    check("mrst_ones", ones_a, 0);
    check("mrst_tog", tog_a, 0);
    tick();
    check("mrst_idle_hold", busy_a, 0);

    // A: full run with resp=1 and a start pulse during RUN
    start_a = 1'b1; tick(); start_a = 1'b0;
    nb = 0;
    while (busy_a && nb < 2000) begin
      nb++;
      start_a = (nb == 5);
      tick();
    end
    start_a = 1'b0;
    check("run1_len", nb, 1024);
    check("run1_done", done_a, 1);
    check("run1_busy", busy_a, 0);
    check("run1_ones", ones_a, 1024);
    tick(); tick();
    check("run1_hold_done", done_a, 1);
    check("run1_hold_ones", ones_a, 1024);

    // A: restart from DONE with resp=0
    resp_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("rs_vec", vec_a, 16'hACE1);
    check("rs_ones", ones_a, 0);
    check("rs_done", done_a, 0);
    check("rs_busy", busy_a, 1);
    nb = 0;
    while (busy_a && nb < 2000) begin
      nb++;
      tick();
    end
    check("run0_len", nb, 1024);
    check("run0_sig", sig_a, 0);
    check("run0_ones", ones_a, 0);
    check("run0_done", done_a, 1);

    // B: single vector, resp tied 1
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("b_c1_busy", busy_b, 1);
    check("b_c1_done", done_b, 0);
    tick();
    check("b_c2_busy", busy_b, 0);
    check("b_c2_done", done_b, 1);
    check("b_sig", sig_b, 16'h0001);
    check("b_ones", ones_b, 1);
    check("b_vec", vec_b, 16'h59C3);

    // C: zero seed, resp = vec[0] -> samples 1,0,0,0
    start_c = 1'b1; tick(); start_c = 1'b0;
    check("c_c1_vec", vec_c, 16'h0001);
    tick();
    check("c_c2_vec", vec_c, 16'h0002);
    tick(); tick(); tick();
    check("c_done", done_c, 1);
    check("c_sig", sig_c, 16'h0008);
    check("c_ones", ones_c, 1);
    check("c_vec", vec_c, 16'h0010);
    check("c_tog", tog_c, TOG_C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
